// File: rtl/corner_out_fifo.sv
// corner_out_fifo
// Collects corners accepted by non-maximal suppression as {address, pixel}
// records, buffers them in a FIFO and drains them over a valid/ready stream.
// At the end of each frame a trailer record is appended that carries the
// frame's corner count and a dropped-corner flag, so the consumer can find
// frame boundaries inside the stream itself.
//
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   inValid/inAddr/inPixel  one-cycle corner strobe with its address and pixel
//   frameDone            one-cycle end-of-frame strobe
//   outReady             consumer accepts the head record
//   outValid/outAddr/outPixel/outLast  registered head record; outLast marks
//                        a trailer (outAddr = count, outPixel[0] = drop flag)
//   level                current occupancy, 0..DEPTH
//   overflow             sticky: a corner has been dropped since reset
module corner_out_fifo #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 15,
    parameter int PIX_W  = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       inValid,
    input  logic [ADDR_W-1:0]          inAddr,
    input  logic [PIX_W-1:0]           inPixel,
    input  logic                       frameDone,
    input  logic                       outReady,
    output logic                       outValid,
    output logic [ADDR_W-1:0]          outAddr,
    output logic [PIX_W-1:0]           outPixel,
    output logic                       outLast,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
);

    localparam int PW    = $clog2(DEPTH);
    localparam int REC_W = 1 + ADDR_W + PIX_W;

    typedef enum logic {
        IDLE,
        PENDING
    } trailerState_t;

    trailerState_t state, nextState;

    logic [REC_W-1:0]  mem [DEPTH];
    logic [PW:0]       wrPtr, rdPtr, rdNext;
    logic [ADDR_W-1:0] frameCount;
    logic              frameDrop;

    logic full, pop, loadValid;
    logic writeCorner, dropCorner, writeTrailer, doWrite;
    logic [REC_W-1:0] writeData;

    // Occupancy counts every record still owned by the FIFO, including the
    // one currently presented at the outputs, since it stays in memory until
    // it is popped.
    assign level = wrPtr - rdPtr;
    assign full  = (level == (PW+1)'(DEPTH));
    assign pop   = outValid && outReady;

    // A corner always beats the trailer; the trailer only slips into a cycle
    // with no corner and free space, so it can never be dropped.
    assign writeCorner  = inValid && !full;
    assign dropCorner   = inValid && full;
    assign writeTrailer = (state == PENDING) && !inValid && !full;
    assign doWrite      = writeCorner || writeTrailer;
    assign writeData    = writeTrailer
                        ? {1'b1, frameCount, {(PIX_W-1){1'b0}}, frameDrop}
                        : {1'b0, inAddr, inPixel};

    // The head slot after this edge's pop. Comparing it with the pre-edge
    // write pointer gives the one-cycle write-to-output latency, because a
    // record written on this same edge is not counted yet.
    assign rdNext    = rdPtr + (PW+1)'(pop);
    assign loadValid = (rdNext != wrPtr);

    // Trailer state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // A repeated frameDone while a trailer is pending is absorbed.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (frameDone)    nextState = PENDING;
            PENDING: if (writeTrailer) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Record storage; the memory itself needs no reset because only slots
    // between the pointers are ever presented.
    always_ff @(posedge clock) begin
        if (doWrite) mem[wrPtr[PW-1:0]] <= writeData;
    end

    // Pointers, per-frame bookkeeping and the sticky overflow flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            frameCount <= '0;
            frameDrop  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (doWrite) wrPtr <= wrPtr + 1'b1;
            rdPtr <= rdNext;
            if (writeTrailer) begin
                frameCount <= '0;
                frameDrop  <= 1'b0;
            end else if (writeCorner && frameCount != '1) begin
                frameCount <= frameCount + 1'b1;
            end
            if (dropCorner) begin
                frameDrop <= 1'b1;
                overflow  <= 1'b1;
            end
        end
    end

    // Registered head record. While stalled the same slot is reloaded, so
    // the outputs hold steady; the data fields keep their last value when
    // nothing is valid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            outValid <= 1'b0;
            outLast  <= 1'b0;
            outAddr  <= '0;
            outPixel <= '0;
        end else begin
            outValid <= loadValid;
            if (loadValid) {outLast, outAddr, outPixel} <= mem[rdNext[PW-1:0]];
        end
    end

endmodule

// File: tb/tb_corner_out_fifo.sv
// tb_corner_out_fifo
// Directed bench for corner_out_fifo: hand-written corner/frame vectors with
// the expected record stream queued alongside, a negedge monitor that checks
// every popped record and output stability during stalls, and direct checks
// of level, overflow and reset behaviour.
module tb_corner_out_fifo;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 15;
    localparam int PIX_W  = 8;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   inValid;
    logic [ADDR_W-1:0]      inAddr;
    logic [PIX_W-1:0]       inPixel;
    logic                   frameDone;
    logic                   outReady;
    logic                   outValid;
    logic [ADDR_W-1:0]      outAddr;
    logic [PIX_W-1:0]       outPixel;
    logic                   outLast;
    logic [$clog2(DEPTH):0] level;
    logic                   overflow;

    int checkCount = 0;
    int passCount  = 0;

    logic [23:0] expQ[$];
    logic [23:0] heldRec;
    logic        holdValid = 1'b0;

    corner_out_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .PIX_W(PIX_W)) dut (
        .clock(clock), .reset(reset),
        .inValid(inValid), .inAddr(inAddr), .inPixel(inPixel),
        .frameDone(frameDone), .outReady(outReady),
        .outValid(outValid), .outAddr(outAddr), .outPixel(outPixel),
        .outLast(outLast), .level(level), .overflow(overflow)
    );

    always #5 clock = ~clock;

    // Single comparison point: counts every check, reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    // Drive one cycle of inputs, then release the strobes.
    task automatic applyStimulus(input logic v, input logic [ADDR_W-1:0] a,
                                 input logic [PIX_W-1:0] p, input logic fd);
        inValid   = v;
        inAddr    = a;
        inPixel   = p;
        frameDone = fd;
        @(posedge clock);
        #1;
        inValid   = 1'b0;
        frameDone = 1'b0;
    endtask

    // Run idle cycles until every expected record has been seen, bounded.
    task automatic waitDrain(input int maxCycles, input logic toggle, input string tag);
        int n = 0;
        while (n < maxCycles && !(expQ.size() == 0 && level == 0)) begin
            applyStimulus(1'b0, '0, '0, 1'b0);
            if (toggle) outReady = ~outReady;
            n++;
        end
        checkOutput({tag, "_pending"}, expQ.size(), 0);
        checkOutput({tag, "_level"}, 32'(level), 0);
    endtask

    // Monitor: checks popped records against the expected stream and that a
    // stalled head record does not change.
    always @(negedge clock) begin
        if (reset) begin
            holdValid = 1'b0;
        end else begin
            if (holdValid)
                checkOutput("holdStable", {outValid, outLast, outAddr, outPixel},
                            {1'b1, heldRec});
            if (outValid && outReady) begin
                if (expQ.size() == 0) checkOutput("unexpectedPop", 1, 0);
                else checkOutput("record", {outLast, outAddr, outPixel}, expQ.pop_front());
                holdValid = 1'b0;
            end else if (outValid) begin
                holdValid = 1'b1;
                heldRec   = {outLast, outAddr, outPixel};
            end else begin
                holdValid = 1'b0;
            end
        end
    end

    initial begin
        reset = 1'b1; inValid = 1'b0; inAddr = '0; inPixel = '0;
        frameDone = 1'b0; outReady = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("rstOutValid", outValid, 0);
        checkOutput("rstOutAddr", outAddr, 0);
        checkOutput("rstOutPixel", outPixel, 0);
        checkOutput("rstOutLast", outLast, 0);
        checkOutput("rstLevel", level, 0);
        checkOutput("rstOverflow", overflow, 0);
        reset = 1'b0;

        // Three corners then a trailer with count 3.
        outReady = 1'b1;
        expQ.push_back({1'b0, 15'h0010, 8'h55});
        applyStimulus(1'b1, 15'h0010, 8'h55, 1'b0);
        expQ.push_back({1'b0, 15'h0020, 8'h66});
        applyStimulus(1'b1, 15'h0020, 8'h66, 1'b0);
        expQ.push_back({1'b0, 15'h0030, 8'h77});
        applyStimulus(1'b1, 15'h0030, 8'h77, 1'b0);
        expQ.push_back({1'b1, 15'd3, 8'h00});
        applyStimulus(1'b0, '0, '0, 1'b1);
        waitDrain(20, 1'b0, "basic");

        // Fill with DEPTH+2 corners while stalled; the last two are dropped.
        outReady = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (i < DEPTH) expQ.push_back({1'b0, 15'(16'h0100 + i), 8'(i + 1)});
            applyStimulus(1'b1, 15'(16'h0100 + i), 8'(i + 1), 1'b0);
        end
        expQ.push_back({1'b1, 15'(DEPTH), 8'h01});
        applyStimulus(1'b0, '0, '0, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b0);
        checkOutput("fullLevel", level, DEPTH);
        checkOutput("fullOverflow", overflow, 1);
        outReady = 1'b1;
        waitDrain(200, 1'b0, "overflow");
        checkOutput("overflowSticky", overflow, 1);

        // frameDone together with a corner, then two more corners.
        expQ.push_back({1'b0, 15'h1234, 8'hA0});
        applyStimulus(1'b1, 15'h1234, 8'hA0, 1'b1);
        expQ.push_back({1'b0, 15'h1235, 8'hA1});
        applyStimulus(1'b1, 15'h1235, 8'hA1, 1'b0);
        expQ.push_back({1'b0, 15'h1236, 8'hA2});
        applyStimulus(1'b1, 15'h1236, 8'hA2, 1'b0);
        expQ.push_back({1'b1, 15'd3, 8'h00});
        waitDrain(20, 1'b0, "coincident");

        // Two empty frames, five cycles apart.
        expQ.push_back({1'b1, 15'd0, 8'h00});
        applyStimulus(1'b0, '0, '0, 1'b1);
        repeat (4) applyStimulus(1'b0, '0, '0, 1'b0);
        expQ.push_back({1'b1, 15'd0, 8'h00});
        applyStimulus(1'b0, '0, '0, 1'b1);
        waitDrain(20, 1'b0, "emptyFrames");

        // Ten corners with outReady toggling every cycle.
        outReady = 1'b0;
        for (int i = 0; i < 10; i++) begin
            expQ.push_back({1'b0, 15'(16'h0200 + i), 8'(8'hC0 + i)});
            applyStimulus(1'b1, 15'(16'h0200 + i), 8'(8'hC0 + i), 1'b0);
            outReady = ~outReady;
        end
        expQ.push_back({1'b1, 15'd10, 8'h00});
        applyStimulus(1'b0, '0, '0, 1'b1);
        outReady = ~outReady;
        waitDrain(100, 1'b1, "toggle");

        // Reset while five records are held and a trailer is pending.
        outReady = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 15'(16'h0300 + i), 8'(i), 1'b0);
        applyStimulus(1'b1, 15'h0304, 8'h04, 1'b1);
        checkOutput("preResetLevel", level, 5);
        reset = 1'b1;
        expQ.delete();
        #1;
        checkOutput("midResetOutValid", outValid, 0);
        checkOutput("midResetLevel", level, 0);
        checkOutput("midResetOverflow", overflow, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        outReady = 1'b1;
        repeat (6) applyStimulus(1'b0, '0, '0, 1'b0);
        checkOutput("postResetOutValid", outValid, 0);
        checkOutput("postResetLevel", level, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
